// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y86_pkg
// Purpose  : Shared Y86-64 definitions: icodes, status codes, register IDs and
//            the machine-state encoding used by the pipeline controller.
// Revision : 1.0  initial release
// ============================================================================
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    // Status codes, fetch-stage encoding
    localparam logic [1:0] STAT_AOK = 2'd3;
    localparam logic [1:0] STAT_HLT = 2'd0;
    localparam logic [1:0] STAT_ADR = 2'd1;
    localparam logic [1:0] STAT_INS = 2'd2;

    // "No register" ID
    localparam logic [3:0] RNONE = 4'hF;

    // Machine state
    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } cpu_state_e;

endpackage : y86_pkg
`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module   : pipe_perf_cnt
// Purpose  : Bank of N saturating up-counters with individual increment
//            enables and a shared synchronous clear (rst).
// Revision : 1.0  initial release
// ============================================================================
module pipe_perf_cnt #(
    parameter int CNT_W = 32,
    parameter int N     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       i_inc,
    output logic [N*CNT_W-1:0] o_cnt
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            // Count up on enable, sticking at all-ones instead of wrapping
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (i_inc[gi] && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign o_cnt[gi*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate

endmodule : pipe_perf_cnt
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Y86-64 five-stage pipeline control. Resolves load/use, ret and
//            mispredict hazards into stall/bubble controls and tracks machine
//            state (init/run/halted/fault). Performance counters are built
//            only when PIPE_CTRL_PERF_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
import y86_pkg::*;

module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_status,
    input  logic [3:0]       W_icode,
    input  logic [1:0]       W_status,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic [1:0]       cpu_state,
    output logic [1:0]       cpu_status
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_retired,
    output logic [CNT_W-1:0] perf_lu_stall,
    output logic [CNT_W-1:0] perf_mispred,
    output logic [CNT_W-1:0] perf_ret_bub
`endif
);

    cpu_state_e r_state;
    cpu_state_e w_state_nxt;
    logic [1:0] r_status;
    logic [1:0] w_status_nxt;

    logic w_lu;
    logic w_rt;
    logic w_mp;
    logic w_exc_m;

    // Hazard detection from the current stage contents
    always_comb begin
        w_lu    = ((E_icode == MRMOVQ) || (E_icode == POPQ)) &&
                  (E_dstM != RNONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        w_rt    = (D_icode == RET) || (E_icode == RET) || (M_icode == RET);
        w_mp    = (E_icode == JXX) && !e_cnd;
        w_exc_m = (m_status != STAT_AOK) || (W_status != STAT_AOK);
    end

    // Control outputs and next state; reset forces the INIT pattern
    always_comb begin
        F_stall      = 1'b0;
        D_stall      = 1'b0;
        W_stall      = 1'b0;
        D_bubble     = 1'b0;
        E_bubble     = 1'b0;
        M_bubble     = 1'b0;
        w_state_nxt  = r_state;
        w_status_nxt = r_status;

        if (rst) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    F_stall     = 1'b1;
                    D_bubble    = 1'b1;
                    E_bubble    = 1'b1;
                    M_bubble    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    F_stall  = w_lu | w_rt;
                    D_stall  = w_lu;
                    D_bubble = w_mp | (w_rt & !w_lu);
                    E_bubble = w_mp | w_lu;
                    M_bubble = w_exc_m;
                    W_stall  = (W_status != STAT_AOK);
                    if (W_status == STAT_HLT) begin
                        w_state_nxt  = ST_HALTED;
                        w_status_nxt = W_status;
                    end else if ((W_status == STAT_ADR) || (W_status == STAT_INS)) begin
                        w_state_nxt  = ST_FAULT;
                        w_status_nxt = W_status;
                    end
                end
                default: begin
                    // HALTED and FAULT: pipe frozen until reset
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    W_stall  = 1'b1;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                end
            endcase
        end
    end

    // Machine state and latched final status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_INIT;
            r_status <= STAT_AOK;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
        end
    end

    assign cpu_state  = r_state;
    assign cpu_status = r_status;

`ifdef PIPE_CTRL_PERF_EN
    localparam int c_n_cnt = 5;

    logic                     w_run;
    logic [c_n_cnt-1:0]       w_inc;
    logic [c_n_cnt*CNT_W-1:0] w_cnt;

    // Event enables; all gated by RUN so counters freeze once halted/faulted
    always_comb begin
        w_run    = (r_state == ST_RUN) && !rst;
        w_inc[0] = w_run;
        w_inc[1] = w_run && (W_status == STAT_AOK) && (W_icode != NOP) && !W_stall;
        w_inc[2] = w_run && w_lu;
        w_inc[3] = w_run && w_mp;
        w_inc[4] = w_run && w_rt && !w_lu;
    end

    pipe_perf_cnt #(
        .CNT_W (CNT_W),
        .N     (c_n_cnt)
    ) u_perf (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_inc),
        .o_cnt (w_cnt)
    );

    assign perf_cycles   = w_cnt[0*CNT_W +: CNT_W];
    assign perf_retired  = w_cnt[1*CNT_W +: CNT_W];
    assign perf_lu_stall = w_cnt[2*CNT_W +: CNT_W];
    assign perf_mispred  = w_cnt[3*CNT_W +: CNT_W];
    assign perf_ret_bub  = w_cnt[4*CNT_W +: CNT_W];
`else
    // Without the counter bank, W_icode and CNT_W have no consumer
    localparam int c_unused_cnt_w = CNT_W;
    logic w_unused_w_icode;
    assign w_unused_w_icode = ^W_icode;
`endif

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Directed self-checking bench for pipe_ctrl. Control outputs are
//            compared as {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall}.
//            Counter checks are active when PIPE_CTRL_PERF_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int CNT_W = 4;

    logic       clk;
    logic       rst;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic       e_cnd;
    logic [1:0] m_status, W_status;
    logic       F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble;
    logic [1:0] cpu_state, cpu_status;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_cycles, perf_retired, perf_lu_stall, perf_mispred, perf_ret_bub;
`endif

    int n_vec;
    int n_err;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .D_icode    (D_icode),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .E_icode    (E_icode),
        .E_dstM     (E_dstM),
        .e_cnd      (e_cnd),
        .M_icode    (M_icode),
        .m_status   (m_status),
        .W_icode    (W_icode),
        .W_status   (W_status),
        .F_stall    (F_stall),
        .D_stall    (D_stall),
        .W_stall    (W_stall),
        .D_bubble   (D_bubble),
        .E_bubble   (E_bubble),
        .M_bubble   (M_bubble),
        .cpu_state  (cpu_state),
        .cpu_status (cpu_status)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_cycles   (perf_cycles),
        .perf_retired  (perf_retired),
        .perf_lu_stall (perf_lu_stall),
        .perf_mispred  (perf_mispred),
        .perf_ret_bub  (perf_ret_bub)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctl();
        return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
    endfunction

    // All stages hold nops, no sources, AOK status
    task automatic set_idle();
        D_icode  = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode  = 4'h1; E_dstM = 4'hF; e_cnd  = 1'b1;
        M_icode  = 4'h1; m_status = 2'd3;
        W_icode  = 4'h1; W_status = 2'd3;
    endtask

    // Advance to the next negedge, inputs return to idle
    task automatic step();
        @(negedge clk);
        set_idle();
    endtask

    // Reset for two cycles; returns at the negedge where state is INIT
    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        #1 check("ctl_in_rst", 32'(ctl()), 32'b101110);
        @(negedge clk);
        #1 check("state_in_rst", 32'(cpu_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        set_idle();

        do_reset();
        #1;
        check("init_state",  32'(cpu_state),  32'd0);
        check("init_ctl",    32'(ctl()),      32'b101110);
        check("init_status", 32'(cpu_status), 32'd3);

        // RUN 1: idle
        step(); #1;
        check("run_state", 32'(cpu_state), 32'd1);
        check("run_idle",  32'(ctl()),     32'b000000);

        // RUN 2: mrmovq into r3, decode reads r3 as srcA
        step(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
        check("lu_srcA", 32'(ctl()), 32'b110100);

        // RUN 3: same load with no destination
        step(); E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF; #1;
        check("lu_none", 32'(ctl()), 32'b000000);

        // RUN 4: popq into r4, decode reads r4 as srcB
        step(); E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4; #1;
        check("lu_popq", 32'(ctl()), 32'b110100);

        // RUN 5: load/use together with ret in D: stall D, no D bubble
        step(); E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; D_icode = 4'h9; #1;
        check("lu_rt", 32'(ctl()), 32'b110100);

        // RUN 6-8: ret walks D -> E -> M
        step(); D_icode = 4'h9; #1;
        check("ret_D", 32'(ctl()), 32'b101000);
        step(); E_icode = 4'h9; #1;
        check("ret_E", 32'(ctl()), 32'b101000);
        step(); M_icode = 4'h9; #1;
        check("ret_M", 32'(ctl()), 32'b101000);

        // RUN 9: mispredicted jump
        step(); E_icode = 4'h7; e_cnd = 1'b0; #1;
        check("mispred", 32'(ctl()), 32'b001100);

        // RUN 10: correctly predicted jump
        step(); E_icode = 4'h7; e_cnd = 1'b1; #1;
        check("jxx_taken", 32'(ctl()), 32'b000000);

        // RUN 11: an OPq retires in W
        step(); W_icode = 4'h6; #1;
`ifdef PIPE_CTRL_PERF_EN
        check("perf_lu",      32'(perf_lu_stall), 32'd3);
        check("perf_ret_bub", 32'(perf_ret_bub),  32'd3);
        check("perf_mispred", 32'(perf_mispred),  32'd1);
        check("perf_retired0", 32'(perf_retired), 32'd0);
`endif
        check("retire_ctl", 32'(ctl()), 32'b000000);

        // RUN 12: halt reaches W
        step(); W_icode = 4'h0; W_status = 2'd0; #1;
        check("halt_ctl",   32'(ctl()),     32'b000011);
        check("halt_state", 32'(cpu_state), 32'd1);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_retired1", 32'(perf_retired), 32'd1);
`endif

        // Frozen in HALTED
        step(); #1;
        check("halted_state",  32'(cpu_state),  32'd2);
        check("halted_status", 32'(cpu_status), 32'd0);
        check("halted_ctl",    32'(ctl()),      32'b110111);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_cycles_halt", 32'(perf_cycles), 32'd12);
`endif
        step(); E_icode = 4'h7; e_cnd = 1'b0; #1;
        check("halted_hold", 32'(cpu_state), 32'd2);
        check("halted_ctl2", 32'(ctl()),     32'b110111);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_cycles_frozen", 32'(perf_cycles), 32'd12);
`endif

        // Reset out of HALTED
        do_reset();
        #1;
        check("rst_halt_state",  32'(cpu_state),  32'd0);
        check("rst_halt_status", 32'(cpu_status), 32'd3);
`ifdef PIPE_CTRL_PERF_EN
        check("rst_cycles",  32'(perf_cycles),  32'd0);
        check("rst_mispred", 32'(perf_mispred), 32'd0);
`endif

        // Address fault in W with an instruction fault in M
        step(); W_status = 2'd1; m_status = 2'd2; #1;
        check("fault_ctl", 32'(ctl()), 32'b000011);
        step(); #1;
        check("fault_state",  32'(cpu_state),  32'd3);
        check("fault_status", 32'(cpu_status), 32'd1);
        check("fault_ctl2",   32'(ctl()),      32'b110111);

        // Reset out of FAULT, then 20 RUN cycles to saturate the 4-bit counter
        do_reset();
        #1 check("rst_fault_state", 32'(cpu_state), 32'd0);
        for (int i = 0; i < 20; i++) step();
        #1;
        check("sat_state", 32'(cpu_state), 32'd1);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_cycles_sat", 32'(perf_cycles),  32'd15);
        check("perf_retired_0",  32'(perf_retired), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_pipe_ctrl
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 core. Each cycle it inspects the decode, execute, memory and writeback stage fields and drives the stall/bubble controls of the F/D/E/M/W pipeline registers. It resolves load/use hazards, `ret` hazards and mispredicted `jXX`. A small state machine tracks machine status (init, run, halted, fault) and freezes the pipe on `halt` or exception retirement. Optional performance counters are compiled in with a macro.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- D_icode  in  4  icode in the D register.
- d_srcA, d_srcB  in  4 each  decode source register IDs; 4'hF means none.
- E_icode  in  4  icode in the E register.
- E_dstM  in  4  memory destination register in the E register.
- e_cnd  in  1  condition outcome computed in execute.
- M_icode  in  4  icode in the M register.
- m_status  in  2  status produced by the memory stage.
- W_icode  in  4  icode in the W register.
- W_status  in  2  status in the W register.
- F_stall, D_stall, W_stall  out  1 each  hold the register.
- D_bubble, E_bubble, M_bubble  out  1 each  load a bubble (nop, status AOK) into the register.
- cpu_state  out  2  0=INIT, 1=RUN, 2=HALTED, 3=FAULT.
- cpu_status  out  2  latched final status, using the fetch encoding (3=AOK, 0=HLT, 1=ADR, 2=INS).
- perf_cycles, perf_retired, perf_lu_stall, perf_mispred, perf_ret_bub  out  CNT_W each  present only under PIPE_CTRL_PERF_EN.

## Operation
Hazard terms (combinational, from current-cycle inputs):
- `lu = (E_icode==5 || E_icode==B) && E_dstM!=F && (E_dstM==d_srcA || E_dstM==d_srcB)`.
- `rt = (D_icode==9 || E_icode==9 || M_icode==9)`.
- `mp = E_icode==7 && !e_cnd`.
- `exc_m = m_status!=AOK || W_status!=AOK`.

Outputs in RUN:
- F_stall = lu | rt.
- D_stall = lu.
- D_bubble = mp | (rt & !lu).
- E_bubble = mp | lu.
- M_bubble = exc_m.
- W_stall = W_status!=AOK.

Precedence rules:
- lu with rt: stall D and do not bubble it.
- mp with lu: cannot co-occur, because E holds a jXX. E_bubble is still defined as the OR.

FSM (registered, transitions on posedge clk):
- INIT: entered on rst. Advances to RUN after exactly one cycle. Outputs: F_stall=1, D/E/M_bubble=1, D_stall=0, W_stall=0.
- RUN: if W_status==HLT, go to HALTED. If W_status is ADR or INS, go to FAULT. cpu_status latches W_status on the transition.
- HALTED / FAULT: terminal until rst. Outputs: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0.

Arithmetic and counter rules:
- All counters are CNT_W bits and saturate at all-ones; they do not wrap.
- perf_cycles increments every RUN cycle.
- perf_retired increments when in RUN, W_status==AOK, W_icode!=1 (nop/bubble) and !W_stall.
- perf_lu_stall increments on lu, perf_mispred on mp, perf_ret_bub on (rt & !lu), each only in RUN.
- Counters freeze in HALTED/FAULT.

## Timing
- Stall/bubble outputs are combinational from stage inputs and state, with zero-cycle latency. The pipeline registers sample them at the same posedge.
- State and counters update on posedge clk.
- Reset values: cpu_state=INIT, cpu_status=AOK, all counters 0.
- Outputs while rst is high take the INIT values: F_stall=1, D/E/M_bubble=1, D_stall=0, W_stall=0.
- rst asserted mid-operation, including in HALTED/FAULT: the next cycle is INIT and the counters are cleared.
- A `ret` costs 3 bubble cycles in D. A mispredict costs 2 cycles (D and E bubbled). A load/use costs 1 cycle.
- A halt reaching W freezes the pipe in the same cycle; cpu_state shows HALTED from the next cycle.

## Configuration
- PIPE_CTRL_PERF_EN defined: the counter bank and the perf_* ports exist.
- Not defined: no counters and no perf_* ports. Control and FSM behaviour are identical either way.

## Structure
- Shared package y86_pkg holds:
  - icode constants (HALT..POPQ);
  - status encodings (STAT_AOK=3, STAT_HLT=0, STAT_ADR=1, STAT_INS=2);
  - RNONE=4'hF;
  - the cpu_state enum.
- One sub-module, pipe_perf_cnt: a generic saturating counter bank (CNT_W, N counters, per-counter increment enables, sync clear). It is instantiated only under the macro.

## Test plan
- rst high 2 cycles, then released: the first cycle after release is INIT with F_stall=1 and bubbles on D/E/M; the next cycle cpu_state=1 and all controls are 0.
- E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. With E_dstM=F -> all 0.
- `ret` walks D->E->M over 3 cycles -> F_stall=1 and D_bubble=1 in each; perf_ret_bub=3.
- E_icode=7, e_cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; perf_mispred increments by 1.
- W_status=HLT (0) -> W_stall=1 the same cycle; next cycle cpu_state=2, cpu_status=0, perf_cycles frozen. Then rst -> INIT and counters 0.
- W_status=ADR (1) with m_status=INS -> M_bubble=1, then cpu_state=3, cpu_status=1. With CNT_W=4, 20 RUN cycles -> perf_cycles holds at 15.
